delay_line_ctrl: RTL and testbench

- Echo/delay engine that owns the sample-delay BRAM.
- Drives its write port (addr1/we/di) and read port 2 (addr2/do2), and mixes the delayed sample with the dry input.
- Sits between the audio input stage and the output/DAC stage; one 32-bit BRAM word per sample, circular buffer of T words.

---
 rtl/delay_line_ctrl_if.sv | 43 ++++
 rtl/delay_line_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_delay_line_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_line_ctrl_if.sv
// rtl/delay_line_ctrl_if.sv - sample stream and delay-BRAM bus bundle for delay_line_ctrl
//
// Purpose: groups the dry-sample input handshake, the processed-sample output
// and the BRAM write/read port signals into one bundle.
// Signals:
//   in_valid/in_ready/in_sample   dry sample handshake (accept on valid && ready)
//   delay_samples/mix/feedback    per-sample controls, captured with the sample
//   bypass                        per-sample dry passthrough
//   out_valid/out_sample          one-cycle processed-sample pulse
//   bram_we/bram_addr1/bram_di    BRAM write port
//   bram_addr2/bram_do2           BRAM delayed-read port (1-cycle registered read)
// Modports: slave = delay engine, master = surrounding system / BRAM.

interface delay_line_ctrl_if #(
  parameter int B  = 15,
  parameter int DW = 24,
  parameter int GW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_sample;
  logic [B-1:0]  delay_samples;
  logic [GW-1:0] mix;
  logic [GW-1:0] feedback;
  logic          bypass;
  logic          out_valid;
  logic [DW-1:0] out_sample;
  logic          bram_we;
  logic [B-1:0]  bram_addr1;
  logic [B-1:0]  bram_addr2;
  logic [31:0]   bram_di;
  logic [31:0]   bram_do2;

  modport slave (
    input  in_valid, in_sample, delay_samples, mix, feedback, bypass, bram_do2,
    output in_ready, out_valid, out_sample, bram_we, bram_addr1, bram_addr2, bram_di
  );

  modport master (
    output in_valid, in_sample, delay_samples, mix, feedback, bypass, bram_do2,
    input  in_ready, out_valid, out_sample, bram_we, bram_addr1, bram_addr2, bram_di
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// rtl/delay_line_ctrl.sv - echo/delay engine owning a circular sample-delay BRAM
//
// Purpose: accepts one dry sample every 4 clocks, reads the sample written
// d_eff samples earlier, mixes it into the output (mix gain) and into the
// value written back to the buffer (feedback gain), with saturation.
// Ports:
//   i_clk   system clock, all logic on rising edge
//   i_rst   synchronous active-high reset
//   bus     delay_line_ctrl_if.slave: sample in/out handshake and BRAM ports
// Parameters: T buffer depth, B address width, DW sample width, GW gain width.

module delay_line_ctrl #(
  parameter int T  = 20000,
  parameter int B  = 15,
  parameter int DW = 24,
  parameter int GW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  delay_line_ctrl_if.slave bus
);

  // Product/sum width: signed sample times signed-extended unsigned gain.
  localparam int PW = DW + GW + 1;

  localparam logic [B:0]   C_T    = (B+1)'(T);
  localparam logic [B:0]   C_TM1  = (B+1)'(T - 1);
  localparam logic [B:0]   C_ONE  = (B+1)'(1);
  localparam logic [B-1:0] C_LAST = B'(T - 1);

  localparam logic signed [PW-1:0] C_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] C_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_MAC,
    S_WR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_accept;
  logic w_in_ready;
  logic w_out_valid;
  logic w_we;

  logic [B-1:0]         r_wr_ptr;
  logic [B-1:0]         r_rd_addr;
  logic signed [DW-1:0] r_x;
  logic [GW-1:0]        r_mix;
  logic [GW-1:0]        r_fb;
  logic                 r_bypass;
  logic signed [DW-1:0] r_out;
  logic signed [DW-1:0] r_wr;

  function automatic logic signed [DW-1:0] f_sat(input logic signed [PW-1:0] v);
    if (v > C_MAX) begin
      f_sat = C_MAX[DW-1:0];
    end else if (v < C_MIN) begin
      f_sat = C_MIN[DW-1:0];
    end else begin
      f_sat = v[DW-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Read address: effective delay clamped to [1, T-1] so the read never hits
  // the slot being written this sample.
  // ---------------------------------------------------------------------------
  logic [B:0] w_dly_e;
  logic [B:0] w_deff_e;
  logic [B:0] w_ptr_e;
  logic [B:0] w_rd_e;

  assign w_dly_e  = {1'b0, bus.delay_samples};
  assign w_deff_e = (w_dly_e == '0)   ? C_ONE :
                    (w_dly_e >= C_T)  ? C_TM1 : w_dly_e;
  assign w_ptr_e  = {1'b0, r_wr_ptr};
  // Result is always < T, so the extra top bit is zero.
  assign w_rd_e   = (w_ptr_e >= w_deff_e) ? (w_ptr_e - w_deff_e)
                                          : (w_ptr_e + C_T - w_deff_e);

  // ---------------------------------------------------------------------------
  // MAC: gains are unsigned Q0.8; the arithmetic shift floors toward -inf.
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] w_d;
  logic signed [GW:0]   w_mix_s;
  logic signed [GW:0]   w_fb_s;
  logic signed [PW-1:0] w_wet_prod;
  logic signed [PW-1:0] w_fb_prod;
  logic signed [PW-1:0] w_wet;
  logic signed [PW-1:0] w_fbv;
  logic signed [PW-1:0] w_out_sum;
  logic signed [PW-1:0] w_wr_sum;
  logic signed [DW-1:0] w_out_sat;
  logic signed [DW-1:0] w_wr_sat;

  assign w_d        = $signed(bus.bram_do2[DW-1:0]);
  assign w_mix_s    = $signed({1'b0, r_mix});
  assign w_fb_s     = $signed({1'b0, r_fb});
  assign w_wet_prod = PW'(w_d) * PW'(w_mix_s);
  assign w_fb_prod  = PW'(w_d) * PW'(w_fb_s);
  assign w_wet      = w_wet_prod >>> GW;
  assign w_fbv      = w_fb_prod >>> GW;
  assign w_out_sum  = PW'(r_x) + w_wet;
  assign w_wr_sum   = PW'(r_x) + w_fbv;
  assign w_out_sat  = f_sat(w_out_sum);
  assign w_wr_sat   = f_sat(w_wr_sum);

  // Upper BRAM word bits only carry sign extension; the read address top bit
  // is structurally zero.
  logic [32-DW:0] w_unused_bits;
  assign w_unused_bits = {bus.bram_do2[31:DW], w_rd_e[B]};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RD;
        end
      end
      S_RD:  w_next = S_MAC;
      S_MAC: w_next = S_WR;
      S_WR: begin
        w_we        = 1'b1;
        w_out_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_addr <= '0;
      r_x       <= '0;
      r_mix     <= '0;
      r_fb      <= '0;
      r_bypass  <= 1'b0;
      r_out     <= '0;
      r_wr      <= '0;
    end else begin
      if (w_accept) begin
        r_x       <= $signed(bus.in_sample);
        r_mix     <= bus.mix;
        r_fb      <= bus.feedback;
        r_bypass  <= bus.bypass;
        r_rd_addr <= w_rd_e[B-1:0];
      end
      if (r_state == S_MAC) begin
        r_out <= r_bypass ? r_x : w_out_sat;
        r_wr  <= r_bypass ? r_x : w_wr_sat;
      end
      if (r_state == S_WR) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_sample = r_out;
  assign bus.bram_we    = w_we;
  assign bus.bram_addr1 = r_wr_ptr;
  assign bus.bram_addr2 = r_rd_addr;
  assign bus.bram_di    = {{(32-DW){r_wr[DW-1]}}, r_wr};

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb/tb_delay_line_ctrl.sv - directed table-driven bench for delay_line_ctrl

module tb_delay_line_ctrl;

  localparam int T  = 8;
  localparam int B  = 4;
  localparam int DW = 24;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;

  always #5 clk = ~clk;

  delay_line_ctrl_if #(.B(B), .DW(DW), .GW(GW)) bus ();

  delay_line_ctrl #(.T(T), .B(B), .DW(DW), .GW(GW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // External BRAM: registered read, write on we.
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bus.bram_we) begin
      mem[bus.bram_addr1] <= bus.bram_di;
    end
    bus.bram_do2 <= mem[bus.bram_addr2];
  end

  int acc_cnt = 0;
  int ov_cnt  = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;
      if (bus.out_valid) ov_cnt <= ov_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [23:0] x;
    logic [3:0]  dly;
    logic [7:0]  mix;
    logic [7:0]  fb;
    logic        byp;
    logic [23:0] e_out;
    logic [3:0]  e_a1;
    logic [3:0]  e_a2;
    logic [31:0] e_di;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [23:0] x, input logic [3:0] d,
                              input logic [7:0] m, input logic [7:0] f, input logic b,
                              input logic [23:0] eo, input logic [3:0] a1,
                              input logic [3:0] a2, input logic [31:0] di);
    vec_t v;
    v.rst = r; v.x = x; v.dly = d; v.mix = m; v.fb = f; v.byp = b;
    v.e_out = eo; v.e_a1 = a1; v.e_a2 = a2; v.e_di = di;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    logic we_early;
    if (v.rst) do_reset();
    @(negedge clk);
    bus.in_sample     = v.x;
    bus.delay_samples = v.dly;
    bus.mix           = v.mix;
    bus.feedback      = v.fb;
    bus.bypass        = v.byp;
    bus.in_valid      = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s ready timeout: got 0 expected 1", tag);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    we_early = 1'b0;
    for (n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.bram_we) we_early = 1'b1;
    end
    chk({tag, " latency"}, 32'(n), 32'd3);
    chk({tag, " we_early"}, 32'(we_early), 32'd0);
    chk({tag, " we"}, 32'(bus.bram_we), 32'd1);
    chk({tag, " out"}, 32'(bus.out_sample), 32'(v.e_out));
    chk({tag, " addr1"}, 32'(bus.bram_addr1), 32'(v.e_a1));
    chk({tag, " addr2"}, 32'(bus.bram_addr2), 32'(v.e_a2));
    chk({tag, " di"}, bus.bram_di, v.e_di);
    @(negedge clk);
    chk({tag, " ov_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " hold"}, 32'(bus.out_sample), 32'(v.e_out));
  endtask

  initial begin
    vec_t v;
    int a0;
    int o0;

    // Impulse: delay 4, mix 0.5, no feedback
    add(1, 24'h100000, 4, 128, 0, 0, 24'h100000, 0, 4, 32'h00100000);
    add(0, 24'h000000, 4, 128, 0, 0, 24'h000000, 1, 5, 32'h0);
    add(0, 24'h000000, 4, 128, 0, 0, 24'h000000, 2, 6, 32'h0);
    add(0, 24'h000000, 4, 128, 0, 0, 24'h000000, 3, 7, 32'h0);
    add(0, 24'h000000, 4, 128, 0, 0, 24'h080000, 4, 0, 32'h0);
    add(0, 24'h000000, 4, 128, 0, 0, 24'h000000, 5, 1, 32'h0);
    // Feedback: delay 2, mix 255, fb 128; last entry crosses the wrap
    add(1, 24'h100000, 2, 255, 128, 0, 24'h100000, 0, 6, 32'h00100000);
    add(0, 24'h000000, 2, 255, 128, 0, 24'h000000, 1, 7, 32'h0);
    add(0, 24'h000000, 2, 255, 128, 0, 24'h0FF000, 2, 0, 32'h00080000);
    add(0, 24'h000000, 2, 255, 128, 0, 24'h000000, 3, 1, 32'h0);
    add(0, 24'h000000, 2, 255, 128, 0, 24'h07F800, 4, 2, 32'h00040000);
    add(0, 24'h000000, 2, 255, 128, 0, 24'h000000, 5, 3, 32'h0);
    add(0, 24'h000000, 2, 255, 128, 0, 24'h03FC00, 6, 4, 32'h00020000);
    add(0, 24'h000000, 2, 255, 128, 0, 24'h000000, 7, 5, 32'h0);
    add(0, 24'h000000, 2, 255, 128, 0, 24'h01FE00, 0, 6, 32'h00010000);
    // Saturation and floor rounding
    add(1, 24'h7FFFFF, 1, 255, 255, 0, 24'h7FFFFF, 0, 7, 32'h007FFFFF);
    add(0, 24'h7FFFFF, 1, 255, 255, 0, 24'h7FFFFF, 1, 0, 32'h007FFFFF);
    add(0, 24'h800000, 1, 0,   0,   0, 24'h800000, 2, 1, 32'hFF800000);
    add(0, 24'h800000, 1, 255, 255, 0, 24'h800000, 3, 2, 32'hFF800000);
    add(0, 24'hFFFFFF, 1, 0,   0,   0, 24'hFFFFFF, 4, 3, 32'hFFFFFFFF);
    add(0, 24'h000000, 1, 1,   255, 0, 24'hFFFFFF, 5, 4, 32'hFFFFFFFF);
    // Delay clamps and bypass
    add(1, 24'h000111, 1,  0,   0,   0, 24'h000111, 0, 7, 32'h00000111);
    add(0, 24'h000222, 1,  0,   0,   0, 24'h000222, 1, 0, 32'h00000222);
    add(0, 24'h000000, 0,  128, 0,   0, 24'h000111, 2, 1, 32'h0);
    add(0, 24'h000000, 8,  128, 0,   0, 24'h000000, 3, 4, 32'h0);
    add(0, 24'h123456, 3,  255, 255, 1, 24'h123456, 4, 1, 32'h00123456);
    add(0, 24'h876543, 15, 0,   0,   1, 24'h876543, 5, 6, 32'hFF876543);
    add(0, 24'h000000, 7,  0,   0,   0, 24'h000000, 6, 7, 32'h0);
    add(0, 24'h000000, 8,  128, 0,   0, 24'h000088, 7, 0, 32'h0);

    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.delay_samples = '0;
    bus.mix = '0;
    bus.feedback = '0;
    bus.bypass = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_sample", 32'(bus.out_sample), 32'd0);
    chk("reset we", 32'(bus.bram_we), 32'd0);
    chk("reset addr1", 32'(bus.bram_addr1), 32'd0);
    chk("reset addr2", 32'(bus.bram_addr2), 32'd0);
    chk("reset di", bus.bram_di, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Wrap: ramp through the circular buffer, delay 3, mix 0.5
    do_reset();
    for (int n = 0; n < 20; n++) begin
      v.rst = 1'b0;
      v.x = 24'(n);
      v.dly = 4'd3;
      v.mix = 8'd128;
      v.fb = 8'd0;
      v.byp = 1'b0;
      v.e_out = (n >= 3) ? 24'(n + (n - 3) / 2) : 24'(n);
      v.e_a1 = 4'(n % 8);
      v.e_a2 = 4'((n + 5) % 8);
      v.e_di = 32'(n);
      run_vec(v, $sformatf("ramp%0d", n));
    end

    // Reset during MAC aborts the sample
    v.rst = 1'b1; v.x = 24'h000010; v.dly = 4'd1; v.mix = 8'd0; v.fb = 8'd0; v.byp = 1'b0;
    v.e_out = 24'h000010; v.e_a1 = 4'd0; v.e_a2 = 4'd7; v.e_di = 32'h10;
    run_vec(v, "pre_abort");
    @(negedge clk);
    bus.in_sample = 24'h000055;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort we", 32'(bus.bram_we), 32'd0);
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort addr1", 32'(bus.bram_addr1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort quiet we%0d", k), 32'(bus.bram_we), 32'd0);
      chk($sformatf("abort quiet ov%0d", k), 32'(bus.out_valid), 32'd0);
    end
    v.rst = 1'b0; v.x = 24'h000066;
    v.e_out = 24'h000066; v.e_a1 = 4'd0; v.e_a2 = 4'd7; v.e_di = 32'h66;
    run_vec(v, "post_abort");

    // in_valid held through RD/MAC/WR must not be accepted
    a0 = acc_cnt;
    o0 = ov_cnt;
    @(negedge clk);
    bus.in_sample = 24'h000123;
    bus.delay_samples = 4'd1;
    bus.mix = 8'd0;
    bus.feedback = 8'd0;
    bus.bypass = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_sample = 24'h007777;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("busy ov", 32'(bus.out_valid), 32'd1);
    chk("busy out", 32'(bus.out_sample), 32'h123);
    chk("busy addr1", 32'(bus.bram_addr1), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("busy accepts", 32'(acc_cnt - a0), 32'd1);
    chk("busy outputs", 32'(ov_cnt - o0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
